// File: rtl/sprite_compositor.sv
// sprite_compositor: final pixel stage between the sprite blocks and the VGA pins.
// It delays the sprite-on flags, active flag and frame-end marker so they line up
// with ROM data that arrives ROM_LAT cycles late. It then picks one colour by
// priority (bullet > alien > player > background) and expands it to 4:4:4.
// It also finds alien/bullet and alien/player overlap once per frame.
// Ports:
//   Pclk, reset             pixel clock, synchronous active-high reset
//   xx, yy, aactive         raster position and active-video flag
//   A1SpriteOn, A1dataout   alien coverage flag and ROM colour (RRRGGGBB)
//   BSpriteOn, Bdataout     bullet coverage flag and ROM colour
//   PSpriteOn, Pdataout     player coverage flag and ROM colour
//   red, green, blue        registered 4-bit VGA colour
//   hit_pulse               frame-end pulse: alien/bullet overlap seen this frame
//   player_hit_pulse        frame-end pulse: alien/player overlap seen this frame
//   hit_count               saturating count of frames with an alien/bullet hit
module sprite_compositor #(
  parameter int unsigned ROM_LAT  = 1,
  parameter logic [7:0]  TRANSP   = 8'h00,
  parameter logic [7:0]  BG_COLOR = 8'h00,
  parameter int unsigned H_LAST   = 639,
  parameter int unsigned V_LAST   = 479
) (
  input  logic       Pclk,
  input  logic       reset,
  input  logic [9:0] xx,
  input  logic [9:0] yy,
  input  logic       aactive,
  input  logic       A1SpriteOn,
  input  logic [7:0] A1dataout,
  input  logic       BSpriteOn,
  input  logic [7:0] Bdataout,
  input  logic       PSpriteOn,
  input  logic [7:0] Pdataout,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue,
  output logic       hit_pulse,
  output logic       player_hit_pulse,
  output logic [7:0] hit_count
);

  localparam int unsigned POS_W = 10;
  localparam int unsigned COL_W = 8;
  localparam int unsigned RGB_W = 12;
  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = 8'hFF;

  // Per-pixel control bits that travel together down the delay line.
  typedef struct packed {
    logic fe;
    logic act;
    logic p_on;
    logic b_on;
    logic a_on;
  } pix_flags_t;

  pix_flags_t             dly_q [ROM_LAT];
  pix_flags_t             dly_d [ROM_LAT];
  logic [RGB_W-1:0]       rgb_q, rgb_d;
  logic                   hit_l_q, hit_l_d;
  logic                   phit_l_q, phit_l_d;
  logic                   hit_pulse_q, hit_pulse_d;
  logic                   phit_pulse_q, phit_pulse_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  pix_flags_t             flags_in;
  pix_flags_t             dl;
  logic                   a_op, b_op, p_op;
  logic                   hit_now, phit_now;
  logic [COL_W-1:0]       sel;

  // Sample the raster/flags and mark the last active pixel of the frame.
  always_comb begin
    flags_in      = '0;
    flags_in.a_on = A1SpriteOn;
    flags_in.b_on = BSpriteOn;
    flags_in.p_on = PSpriteOn;
    flags_in.act  = aactive;
    flags_in.fe   = (xx == POS_W'(H_LAST)) && (yy == POS_W'(V_LAST));
  end

  // ROM_LAT-deep delay line so flags land on the same cycle as their ROM data.
  always_comb begin
    for (int unsigned i = 0; i < ROM_LAT; i++) begin
      dly_d[i] = '0;
    end
    dly_d[0] = flags_in;
    for (int unsigned i = 1; i < ROM_LAT; i++) begin
      dly_d[i] = dly_q[i-1];
    end
  end

  // Colour select and collision bookkeeping on the aligned pixel.
  always_comb begin
    dl       = dly_q[ROM_LAT-1];
    a_op     = dl.a_on && (A1dataout != TRANSP);
    b_op     = dl.b_on && (Bdataout  != TRANSP);
    p_op     = dl.p_on && (Pdataout  != TRANSP);

    sel = BG_COLOR;
    if (b_op) begin
      sel = Bdataout;
    end else if (a_op) begin
      sel = A1dataout;
    end else if (p_op) begin
      sel = Pdataout;
    end

    rgb_d = '0;
    if (dl.act) begin
      rgb_d = {sel[7:5], sel[7], sel[4:2], sel[4], sel[1:0], sel[1:0]};
    end

    // Overlap during blanking never counts.
    hit_now  = dl.act && a_op && b_op;
    phit_now = dl.act && a_op && p_op;

    // The last pixel's own overlap is folded into this frame's pulse, and the
    // latches restart empty for the next frame.
    hit_pulse_d  = dl.fe && (hit_l_q  || hit_now);
    phit_pulse_d = dl.fe && (phit_l_q || phit_now);
    hit_l_d      = dl.fe ? 1'b0 : (hit_l_q  || hit_now);
    phit_l_d     = dl.fe ? 1'b0 : (phit_l_q || phit_now);

    cnt_d = cnt_q;
    if (hit_pulse_d && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers; reset also drops any half-finished frame.
  always_ff @(posedge Pclk) begin
    if (reset) begin
      for (int unsigned i = 0; i < ROM_LAT; i++) begin
        dly_q[i] <= '0;
      end
      rgb_q        <= '0;
      hit_l_q      <= 1'b0;
      phit_l_q     <= 1'b0;
      hit_pulse_q  <= 1'b0;
      phit_pulse_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      for (int unsigned i = 0; i < ROM_LAT; i++) begin
        dly_q[i] <= dly_d[i];
      end
      rgb_q        <= rgb_d;
      hit_l_q      <= hit_l_d;
      phit_l_q     <= phit_l_d;
      hit_pulse_q  <= hit_pulse_d;
      phit_pulse_q <= phit_pulse_d;
      cnt_q        <= cnt_d;
    end
  end

  assign red              = rgb_q[11:8];
  assign green            = rgb_q[7:4];
  assign blue             = rgb_q[3:0];
  assign hit_pulse        = hit_pulse_q;
  assign player_hit_pulse = phit_pulse_q;
  assign hit_count        = cnt_q;

endmodule

// File: tb/tb_sprite_compositor.sv
// Bench for sprite_compositor: two instances (ROM_LAT 1 and 3) on a small raster.
// Each pixel is a record. A model computes each pixel's colour and each frame's
// overlap result from that record. Literal expectations carried on chosen
// records pin the model.
module tb_sprite_compositor;

  localparam int unsigned H_LAST = 9;
  localparam int unsigned V_LAST = 3;
  localparam int unsigned H_TOT  = 12;
  localparam int unsigned V_TOT  = 5;
  localparam logic [7:0]  TRANSP = 8'h00;
  localparam logic [7:0]  BG     = 8'h25;

  localparam int M_QUIET  = 0;
  localparam int M_RSTBEG = 1;
  localparam int M_PROBE  = 2;
  localparam int M_HIT    = 3;
  localparam int M_PHIT   = 4;
  localparam int M_PFILL  = 5;
  localparam int M_HITRST = 6;
  localparam int M_RAND   = 7;
  localparam int M_RANDR  = 8;

  typedef struct packed {
    logic        rst;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        act;
    logic        a_on;
    logic [7:0]  a_col;
    logic        b_on;
    logic [7:0]  b_col;
    logic        p_on;
    logic [7:0]  p_col;
    logic        lit_rgb_en;
    logic [11:0] lit_rgb;
    logic        lit_fe_en;
    logic        lit_hp;
    logic        lit_php;
    logic [7:0]  lit_cnt;
  } rec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  rec_t cur = '0;
  rec_t gen_h [4] = '{default: '0};

  logic [3:0] red_o   [2];
  logic [3:0] green_o [2];
  logic [3:0] blue_o  [2];
  logic       hp_o    [2];
  logic       php_o   [2];
  logic [7:0] cnt_o   [2];

  sprite_compositor #(.ROM_LAT(1), .TRANSP(TRANSP), .BG_COLOR(BG),
                      .H_LAST(H_LAST), .V_LAST(V_LAST)) dut_l1 (
    .Pclk(clk), .reset(cur.rst), .xx(cur.x), .yy(cur.y), .aactive(cur.act),
    .A1SpriteOn(cur.a_on), .A1dataout(gen_h[1].a_col),
    .BSpriteOn(cur.b_on),  .Bdataout(gen_h[1].b_col),
    .PSpriteOn(cur.p_on),  .Pdataout(gen_h[1].p_col),
    .red(red_o[0]), .green(green_o[0]), .blue(blue_o[0]),
    .hit_pulse(hp_o[0]), .player_hit_pulse(php_o[0]), .hit_count(cnt_o[0]));

  sprite_compositor #(.ROM_LAT(3), .TRANSP(TRANSP), .BG_COLOR(BG),
                      .H_LAST(H_LAST), .V_LAST(V_LAST)) dut_l3 (
    .Pclk(clk), .reset(cur.rst), .xx(cur.x), .yy(cur.y), .aactive(cur.act),
    .A1SpriteOn(cur.a_on), .A1dataout(gen_h[3].a_col),
    .BSpriteOn(cur.b_on),  .Bdataout(gen_h[3].b_col),
    .PSpriteOn(cur.p_on),  .Pdataout(gen_h[3].p_col),
    .red(red_o[1]), .green(green_o[1]), .blue(blue_o[1]),
    .hit_pulse(hp_o[1]), .player_hit_pulse(php_o[1]), .hit_count(cnt_o[1]));

  // ---------------- reference model ----------------
  rec_t        hist [4] = '{default: '0};
  rec_t        em   [2] = '{default: '0};
  logic [11:0] e_rgb [2] = '{default: '0};
  logic        e_hp  [2] = '{default: 1'b0};
  logic        e_php [2] = '{default: 1'b0};
  logic [7:0]  e_cnt [2] = '{default: '0};
  logic        acc_h [2] = '{default: 1'b0};
  logic        acc_p [2] = '{default: 1'b0};
  logic        post_rst = 1'b0;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic logic [11:0] expand(input logic [7:0] c);
    return {c[7:5], c[7], c[4:2], c[4], c[1:0], c[1:0]};
  endfunction

  // Outcome at this edge for the instance of latency l: the record from l edges
  // ago is shown, unless a reset at any edge since then discarded it.
  task automatic model_step(input int i, input int l);
    rec_t r;
    logic valid, aop, bop, pop, fe, hnow, pnow;
    logic [7:0] sel;
    valid = 1'b1;
    for (int k = 0; k <= l; k++) if (hist[k].rst) valid = 1'b0;
    r = valid ? hist[l] : '0;
    em[i] = r;
    aop = r.a_on && (r.a_col != TRANSP);
    bop = r.b_on && (r.b_col != TRANSP);
    pop = r.p_on && (r.p_col != TRANSP);
    if (bop) sel = r.b_col;
    else if (aop) sel = r.a_col;
    else if (pop) sel = r.p_col;
    else sel = BG;
    e_rgb[i] = r.act ? expand(sel) : 12'h000;
    hnow = r.act && aop && bop;
    pnow = r.act && aop && pop;
    fe   = valid && (r.x == 10'(H_LAST)) && (r.y == 10'(V_LAST));
    if (hist[0].rst) begin
      acc_h[i] = 1'b0; acc_p[i] = 1'b0;
      e_hp[i] = 1'b0; e_php[i] = 1'b0; e_cnt[i] = 8'd0;
    end else if (fe) begin
      e_hp[i]  = acc_h[i] || hnow;
      e_php[i] = acc_p[i] || pnow;
      acc_h[i] = 1'b0; acc_p[i] = 1'b0;
      if (e_hp[i] && e_cnt[i] != 8'd255) e_cnt[i] = e_cnt[i] + 8'd1;
    end else begin
      e_hp[i] = 1'b0; e_php[i] = 1'b0;
      acc_h[i] = acc_h[i] || hnow;
      acc_p[i] = acc_p[i] || pnow;
    end
  endtask

  always @(posedge clk) begin
    for (int k = 3; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = cur;
    model_step(0, 1);
    model_step(1, 3);
    post_rst = !hist[0].rst && hist[1].rst;
    cyc = cyc + 1;
  end

  // ---------------- compare process ----------------
  task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s lat%0d cyc=%0d: got %0h want %0h", nm, (inst == 0) ? 1 : 3, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cyc > 0) begin
      for (int i = 0; i < 2; i++) begin
        chk("rgb", i, 32'({red_o[i], green_o[i], blue_o[i]}), 32'(e_rgb[i]));
        chk("hit_pulse", i, 32'(hp_o[i]), 32'(e_hp[i]));
        chk("player_hit_pulse", i, 32'(php_o[i]), 32'(e_php[i]));
        chk("hit_count", i, 32'(cnt_o[i]), 32'(e_cnt[i]));
        if (em[i].lit_rgb_en)
          chk("lit_rgb", i, 32'({red_o[i], green_o[i], blue_o[i]}), 32'(em[i].lit_rgb));
        if (em[i].lit_fe_en) begin
          chk("lit_hit_pulse", i, 32'(hp_o[i]), 32'(em[i].lit_hp));
          chk("lit_player_hit_pulse", i, 32'(php_o[i]), 32'(em[i].lit_php));
          chk("lit_hit_count", i, 32'(cnt_o[i]), 32'(em[i].lit_cnt));
        end
        if (post_rst)
          chk("lit_post_reset", i,
              32'({red_o[i], green_o[i], blue_o[i], hp_o[i], php_o[i], cnt_o[i]}), 32'(0));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic push(input rec_t r);
    for (int k = 3; k > 0; k--) gen_h[k] = gen_h[k-1];
    gen_h[0] = r;
    cur = r;
  endtask

  task automatic rand_sprite(output logic on, output logic [7:0] col, input int odds);
    on  = ($urandom % 32'(odds)) == 0;
    col = (($urandom % 4) == 0) ? 8'h00 : 8'($urandom);
  endtask

  task automatic run_frame(input int mode, input int hx, input int hy,
                           input logic fe_en, input logic lhp, input logic lphp,
                           input logic [7:0] lcnt);
    rec_t r;
    int idx;
    for (int y = 0; y < int'(V_TOT); y++) begin
      for (int x = 0; x < int'(H_TOT); x++) begin
        r   = '0;
        idx = y * int'(H_TOT) + x;
        r.x = 10'(x);
        r.y = 10'(y);
        r.act = (x <= int'(H_LAST)) && (y <= int'(V_LAST));
        case (mode)
          M_RSTBEG: if (idx < 3) begin
            r.rst = 1'b1;
            r.a_on = 1'b1; r.a_col = 8'hE3;
            r.b_on = 1'b1; r.b_col = 8'h1C;
            r.p_on = 1'b1; r.p_col = 8'hFF;
          end
          M_PROBE: begin
            if (x == 2 && y == 1) begin
              r.a_on = 1'b1; r.a_col = 8'hE0; r.lit_rgb_en = 1'b1; r.lit_rgb = 12'hF00;
            end
            if (x == 5 && y == 1) begin
              r.a_on = 1'b1; r.a_col = 8'h00; r.lit_rgb_en = 1'b1; r.lit_rgb = 12'h225;
            end
          end
          M_HIT, M_HITRST: begin
            if (x == hx && y == hy) begin
              r.a_on = 1'b1; r.a_col = 8'hE3;
              r.b_on = 1'b1; r.b_col = 8'h1C;
              r.lit_rgb_en = 1'b1; r.lit_rgb = 12'h0F0;
            end
            if (mode == M_HITRST && y == 1 && x >= 7 && x <= 9) r.rst = 1'b1;
          end
          M_PHIT: if (x == hx && y == hy) begin
            r.a_on = 1'b1; r.a_col = 8'hE3;
            r.p_on = 1'b1; r.p_col = 8'hFF;
            r.lit_rgb_en = 1'b1; r.lit_rgb = 12'hF0F;
          end
          M_PFILL: begin
            r.p_on = 1'b1; r.p_col = 8'hFF;
            if (y == 1 && x == 9)  begin r.lit_rgb_en = 1'b1; r.lit_rgb = 12'hFFF; end
            if (y == 1 && x == 10) begin r.lit_rgb_en = 1'b1; r.lit_rgb = 12'h000; end
          end
          M_RAND, M_RANDR: begin
            rand_sprite(r.a_on, r.a_col, 3);
            rand_sprite(r.b_on, r.b_col, 4);
            rand_sprite(r.p_on, r.p_col, 3);
            if (mode == M_RANDR) r.rst = ($urandom % 100) == 0;
          end
          default: ;
        endcase
        if (x == int'(H_LAST) && y == int'(V_LAST) && fe_en) begin
          r.lit_fe_en = 1'b1; r.lit_hp = lhp; r.lit_php = lphp; r.lit_cnt = lcnt;
        end
        push(r);
        @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    run_frame(M_RSTBEG, 0, 0, 1'b1, 1'b0, 1'b0, 8'd0);
    run_frame(M_PROBE,  0, 0, 1'b1, 1'b0, 1'b0, 8'd0);
    run_frame(M_HIT,    4, 2, 1'b1, 1'b1, 1'b0, 8'd1);
    run_frame(M_HIT,    9, 3, 1'b1, 1'b1, 1'b0, 8'd2);
    run_frame(M_QUIET,  0, 0, 1'b1, 1'b0, 1'b0, 8'd2);
    run_frame(M_PHIT,   3, 0, 1'b1, 1'b0, 1'b1, 8'd2);
    run_frame(M_PFILL,  0, 0, 1'b1, 1'b0, 1'b0, 8'd2);
    run_frame(M_HITRST, 1, 1, 1'b1, 1'b0, 1'b0, 8'd0);
    for (int f = 0; f < 30; f++) run_frame(M_RAND, 0, 0, 1'b0, 1'b0, 1'b0, 8'd0);
    for (int f = 0; f < 260; f++)
      run_frame(M_HIT, int'($urandom_range(0, H_LAST)), int'($urandom_range(0, V_LAST)),
                1'b0, 1'b0, 1'b0, 8'd0);
    run_frame(M_HIT, 2, 2, 1'b1, 1'b1, 1'b0, 8'd255);
    run_frame(M_HIT, 9, 3, 1'b1, 1'b1, 1'b0, 8'd255);
    for (int f = 0; f < 10; f++) run_frame(M_RANDR, 0, 0, 1'b0, 1'b0, 1'b0, 8'd0);
    run_frame(M_QUIET, 0, 0, 1'b0, 1'b0, 1'b0, 8'd0);
    repeat (2) @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sprite_compositor.md
Name: sprite_compositor

Overview:
- Downstream pixel stage. Consumes per-pixel sprite-on flags and 8-bit ROM colour data from the alien, bullet and player movement blocks, and drives the VGA colour pins.
- Aligns the sprite-on flags to the one-cycle-late ROM data, resolves draw priority and colour-key transparency, and blanks outside the active area.
- Detects alien/bullet and alien/player overlap per frame and reports it once per frame as a pulse plus a saturating hit counter.

Parameters:
- ROM_LAT, 1, cycles from a registered SpriteOn to valid ROM data; legal values 1..3.
- TRANSP, 8'h00, colour key; a sprite pixel equal to this value is not drawn and does not collide.
- BG_COLOR, 8'h00, background colour in RRRGGGBB format.
- H_LAST, 639, last active xx.
- V_LAST, 479, last active yy.

Ports:
- Pclk, input, 1, pixel clock.
- reset, input, 1, reset; synchronous, active-high.
- xx, input, 10, current pixel column from the VGA timing block.
- yy, input, 10, current pixel row.
- aactive, input, 1, active-video flag, same timing as xx/yy.
- A1SpriteOn, input, 1, alien coverage flag (registered, leads A1dataout by ROM_LAT).
- A1dataout, input, 8, alien pixel colour, RRRGGGBB.
- BSpriteOn, input, 1, bullet coverage flag.
- Bdataout, input, 8, bullet pixel colour.
- PSpriteOn, input, 1, player coverage flag.
- Pdataout, input, 8, player pixel colour.
- red, output, 4, VGA red.
- green, output, 4, VGA green.
- blue, output, 4, VGA blue.
- hit_pulse, output, 1, one-cycle pulse at frame end if any alien/bullet overlap occurred that frame.
- player_hit_pulse, output, 1, one-cycle pulse at frame end if any alien/player overlap occurred that frame.
- hit_count, output, 8, frames with an alien/bullet hit; saturates at 255.

Behaviour:
- Reset (synchronous): red, green, blue = 0; both pulses = 0; hit_count = 0; all delay-line stages and hit latches = 0. Any frame in progress when reset asserts is discarded; no pulse is generated for it.
- Alignment:
  - A1SpriteOn, BSpriteOn, PSpriteOn and aactive each pass through a ROM_LAT-deep shift register.
  - frame_end = (xx==H_LAST && yy==V_LAST) passes through the same depth.
  - The delayed signals are called a_on, b_on, p_on, act_d and fe_d.
- Opaque qualifiers, using data at its input value:
  - a_op = a_on && A1dataout != TRANSP.
  - b_op and p_op are formed the same way from b_on/Bdataout and p_on/Pdataout.
- Colour select, registered once more into red/green/blue:
  - If act_d = 0, output 0.
  - Else b_op selects Bdataout, else a_op selects A1dataout, else p_op selects Pdataout, else BG_COLOR.
  - Priority is bullet > alien > player > background.
- Expansion of the selected byte c[7:0]:
  - red = {c[7:5], c[7]}.
  - green = {c[4:2], c[4]}.
  - blue = {c[1:0], c[1:0]}.
- Total latency: an xx/yy/flag sample at cycle t appears on the colour pins at t+ROM_LAT+1.
- Collision:
  - hit_l is set on any cycle with act_d && a_op && b_op.
  - phit_l is set on any cycle with act_d && a_op && p_op.
  - Both are sticky until frame end.
- Frame end, on a cycle with fe_d = 1:
  - hit_pulse <= hit_l | (act_d && a_op && b_op), so an overlap on the last pixel counts for this frame.
  - player_hit_pulse is formed the same way from phit_l.
  - hit_l and phit_l are cleared to 0, not set, on this cycle.
  - hit_count increments if the hit_pulse term is 1 and hit_count < 255; it holds at 255.
- Pulses are exactly one cycle wide and are 0 on every cycle where fe_d = 0.
- Overlap while act_d = 0 (blanking) never sets a latch.

Test Plan:
- Reset for 3 cycles with sprites active, ROM_LAT=1 → red/green/blue = 0, both pulses = 0, hit_count = 0 on the cycle after reset deasserts.
- A1SpriteOn=1 at xx=100,yy=50, A1dataout=8'hE0 one cycle later → output at xx=102 is red=4'hF, green=0, blue=0. The same pixel with A1dataout=8'h00 → BG_COLOR is shown.
- Bullet and alien both opaque on the same pixel (B=8'h1C, A=8'hE3) → output is green=4'hF, red=0, blue=0. hit_pulse=1 for exactly one cycle at the aligned frame end; hit_count=1.
- Overlap only at the final pixel (639,479) → hit_pulse asserted that same frame end. A following frame with no overlap → hit_pulse stays 0 and hit_count is unchanged.
- 256 consecutive frames each containing a hit → hit_count reaches 255 and stays 255. Alien/player overlap raises player_hit_pulse only, and hit_count does not change.
- ROM_LAT=3 with aactive falling at xx=640 → colour pins go 0 exactly 4 cycles later. Reset asserted mid-frame after an overlap → no pulse at the next frame end.
